// File: rtl/vram_sched_pkg.sv
`default_nettype none
// vram_sched_pkg: scheduler state encoding and default VRAM geometry shared with VGAGenerator (rev 1.0).
package vram_sched_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 10;
    localparam int DEF_DEPTH  = 1024;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_VBL = 2'd1,
        SWEEP    = 2'd2,
        DONE     = 2'd3
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/vram_sweep_counter.sv
`default_nettype none
// vram_sweep_counter: sweep address generator counting 0..DEPTH-1, flags the final address (rev 1.0).
module vram_sweep_counter
    import vram_sched_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              enable,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    always_ff @(posedge clk) begin
        if (rst || start) begin
            addr <= '0;
        end else if (enable) begin
            addr <= addr + ADDR_W'(1);
        end
    end

    assign last = (addr == LAST_ADDR);

endmodule
`default_nettype wire

// File: rtl/vram_write_scheduler.sv
`default_nettype none
// vram_write_scheduler: shares the VRAM write port between a sample stream and a full-screen fill sweep (rev 1.0).
// Optional VRAM_RAMP_PATTERN_EN adds rampReq, which sweeps an address ramp instead of clearValue.
module vram_write_scheduler
    import vram_sched_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int DEPTH          = DEF_DEPTH,
    parameter int SYNC_TO_VBLANK = 1
) (
    input  logic              inClock,
    input  logic              reset,
    input  logic              vBlank,
    input  logic              sampleValid,
    input  logic [ADDR_W-1:0] sampleAddr,
    input  logic [DATA_W-1:0] sampleData,
    output logic              sampleReady,
    input  logic              clearReq,
    input  logic [DATA_W-1:0] clearValue,
`ifdef VRAM_RAMP_PATTERN_EN
    input  logic              rampReq,
`endif
    output logic              vramWe,
    output logic [ADDR_W-1:0] vramWriteAddr,
    output logic [DATA_W-1:0] vramInData,
    output logic              busy,
    output logic              sweepDone
);

    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    sched_state_t      state;
    sched_state_t      state_next;
    logic              pending;
    logic [DATA_W-1:0] fill_value;
    logic              sweep_req;
    logic              sweep_take;
    logic              sample_take;
    logic              in_range;
    logic              cnt_start;
    logic              cnt_enable;
    logic              cnt_last;
    logic [ADDR_W-1:0] cnt_addr;
    logic [DATA_W-1:0] sweep_word;

    assign sampleReady = (state == IDLE) && !pending;
    assign sample_take = sampleValid && sampleReady;
    assign in_range    = ({1'b0, sampleAddr} < DEPTH_LIM);
    assign sweep_take  = (state == IDLE) && !pending && sweep_req;

`ifdef VRAM_RAMP_PATTERN_EN
    logic              ramp_mode;
    logic [DATA_W-1:0] ramp_word;

    if (DATA_W > ADDR_W) begin : g_ramp_ext
        assign ramp_word = {{(DATA_W - ADDR_W){1'b0}}, cnt_addr};
    end else begin : g_ramp_trunc
        assign ramp_word = cnt_addr[DATA_W-1:0];
    end

    assign sweep_req  = clearReq || rampReq;
    assign sweep_word = ramp_mode ? ramp_word : fill_value;

    // A simultaneous clear overrides the ramp request.
    always_ff @(posedge inClock) begin
        if (reset) begin
            ramp_mode <= 1'b0;
        end else if (sweep_take) begin
            ramp_mode <= !clearReq;
        end
    end
`else
    assign sweep_req  = clearReq;
    assign sweep_word = fill_value;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (sweep_take) state_next = (SYNC_TO_VBLANK != 0) ? WAIT_VBL : SWEEP;
            WAIT_VBL: if (vBlank) state_next = SWEEP;
            SWEEP:    if (cnt_last) state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    assign cnt_start  = (state_next == SWEEP) && (state != SWEEP);
    assign cnt_enable = (state == SWEEP) && !cnt_last;

    vram_sweep_counter #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_sweep_counter (
        .clk    (inClock),
        .rst    (reset),
        .start  (cnt_start),
        .enable (cnt_enable),
        .addr   (cnt_addr),
        .last   (cnt_last)
    );

    // Write port is fully registered, so every write lands one cycle after its decision.
    always_ff @(posedge inClock) begin
        if (reset) begin
            state         <= IDLE;
            pending       <= 1'b0;
            fill_value    <= '0;
            vramWe        <= 1'b0;
            vramWriteAddr <= '0;
            vramInData    <= '0;
            busy          <= 1'b0;
            sweepDone     <= 1'b0;
        end else begin
            state     <= state_next;
            busy      <= (state_next == WAIT_VBL) || (state_next == SWEEP) || (state_next == DONE);
            sweepDone <= (state == DONE);
            vramWe    <= 1'b0;
            if (sweep_take) begin
                pending <= 1'b1;
            end else if (state == DONE) begin
                pending <= 1'b0;
            end
            if (sweep_take && clearReq) begin
                fill_value <= clearValue;
            end
            if (sample_take && in_range) begin
                vramWe        <= 1'b1;
                vramWriteAddr <= sampleAddr;
                vramInData    <= sampleData;
            end else if (state == SWEEP) begin
                vramWe        <= 1'b1;
                vramWriteAddr <= cnt_addr;
                vramInData    <= sweep_word;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vram_write_scheduler.sv
`default_nettype none
// tb_vram_write_scheduler: randomized and directed checks of two scheduler builds against a write-list model (rev 1.0).
module tb_vram_write_scheduler;

    typedef struct packed {
        logic [31:0] stamp;
        logic [9:0]  a;
        logic [9:0]  d;
    } wr_t;

    logic       inClock = 1'b0;
    logic       reset, vBlank;
    logic       valid1, valid2, clear1, clear2;
    logic [9:0] sAddr, sData, cValue;
    logic       ready1, we1, busy1, sd1;
    logic       ready2, we2, busy2, sd2;
    logic [9:0] wa1, wd1, wa2, wd2;
`ifdef VRAM_RAMP_PATTERN_EN
    logic       ramp1, ramp2;
`endif

    int  cyc = 0;
    int  compared = 0;
    int  mismatched = 0;
    int  c;
    int  first;
    wr_t obs1[$], obs2[$], exp1[$], exp2[$];
    int  dq1[$], dq2[$];

    vram_write_scheduler #(.ADDR_W(10), .DATA_W(10), .DEPTH(1024), .SYNC_TO_VBLANK(1)) u_dut1 (
        .inClock(inClock), .reset(reset), .vBlank(vBlank),
        .sampleValid(valid1), .sampleAddr(sAddr), .sampleData(sData), .sampleReady(ready1),
        .clearReq(clear1), .clearValue(cValue),
`ifdef VRAM_RAMP_PATTERN_EN
        .rampReq(ramp1),
`endif
        .vramWe(we1), .vramWriteAddr(wa1), .vramInData(wd1), .busy(busy1), .sweepDone(sd1)
    );

    vram_write_scheduler #(.ADDR_W(10), .DATA_W(10), .DEPTH(1000), .SYNC_TO_VBLANK(0)) u_dut2 (
        .inClock(inClock), .reset(reset), .vBlank(vBlank),
        .sampleValid(valid2), .sampleAddr(sAddr), .sampleData(sData), .sampleReady(ready2),
        .clearReq(clear2), .clearValue(cValue),
`ifdef VRAM_RAMP_PATTERN_EN
        .rampReq(ramp2),
`endif
        .vramWe(we2), .vramWriteAddr(wa2), .vramInData(wd2), .busy(busy2), .sweepDone(sd2)
    );

    always #5 inClock = ~inClock;
    always @(posedge inClock) cyc <= cyc + 1;

    // Every observed write and done pulse is stamped with the index of the edge that produced it.
    always @(negedge inClock) begin
        if (we1) obs1.push_back('{stamp: cyc, a: wa1, d: wd1});
        if (we2) obs2.push_back('{stamp: cyc, a: wa2, d: wd2});
        if (sd1) dq1.push_back(cyc);
        if (sd2) dq2.push_back(cyc);
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_push(int which, int stamp, logic [9:0] a, logic [9:0] d);
        wr_t e;
        e = '{stamp: 32'(stamp), a: a, d: d};
        if (which == 1) exp1.push_back(e);
        else exp2.push_back(e);
    endtask

    task automatic exp_sweep(int which, int start, int depth, logic [9:0] v, bit ramp);
        for (int a = 0; a < depth; a++) exp_push(which, start + a, 10'(a), ramp ? 10'(a) : v);
    endtask

    task automatic cmp_q(string tag, input wr_t e[$], input wr_t o[$]);
        bit ok = 1'b1;
        check({tag, ".count"}, o.size(), e.size());
        for (int i = 0; i < e.size() && i < o.size() && ok; i++) begin
            compared++;
            assert (o[i] === e[i]) else begin
                mismatched++;
                ok = 1'b0;
                $error("FAIL %s[%0d]: observed t=%0d a=%0d d=%h, expected t=%0d a=%0d d=%h",
                       tag, i, o[i].stamp, o[i].a, o[i].d, e[i].stamp, e[i].a, e[i].d);
            end
        end
    endtask

    task automatic check_writes(string tag);
        cmp_q({tag, ".dut1"}, exp1, obs1);
        cmp_q({tag, ".dut2"}, exp2, obs2);
        exp1.delete(); obs1.delete(); exp2.delete(); obs2.delete();
    endtask

    task automatic check_done(string tag, int n1, int s1, int n2, int s2);
        check({tag, ".done_n1"}, dq1.size(), n1);
        if (dq1.size() > 0 && n1 > 0) check({tag, ".done_t1"}, dq1[0], s1);
        check({tag, ".done_n2"}, dq2.size(), n2);
        if (dq2.size() > 0 && n2 > 0) check({tag, ".done_t2"}, dq2[0], s2);
        dq1.delete(); dq2.delete();
    endtask

    task automatic wait_to(int s);
        while (cyc < s) @(negedge inClock);
    endtask

    initial begin
        reset = 1'b1; vBlank = 1'b0; valid1 = 1'b0; valid2 = 1'b0;
        clear1 = 1'b0; clear2 = 1'b0; sAddr = '0; sData = '0; cValue = '0;
`ifdef VRAM_RAMP_PATTERN_EN
        ramp1 = 1'b0; ramp2 = 1'b0;
`endif
        repeat (3) @(negedge inClock);
        check("rst.we", we1, 0);
        check("rst.addr", wa1, 0);
        check("rst.data", wd1, 0);
        check("rst.busy", busy1, 0);
        check("rst.done", sd1, 0);
        check("rst.ready", ready1, 1);
        check("rst.we2", we2, 0);
        check("rst.busy2", busy2, 0);
        reset = 1'b0;
        obs1.delete(); obs2.delete(); dq1.delete(); dq2.delete();

        // Back-to-back stream of four words.
        for (int i = 0; i < 4; i++) begin
            @(negedge inClock);
            check("stream4.ready", ready1, 1);
            valid1 = 1'b1; sAddr = 10'(5 + i); sData = 10'(10'h3FF - i);
            exp_push(1, cyc + 1, sAddr, sData);
        end
        @(negedge inClock); valid1 = 1'b0;
        repeat (3) @(negedge inClock);
        check_writes("stream4");

        // Address boundary on the 1000-word build: 999 written, 1000 dropped, port holds.
        @(negedge inClock); valid2 = 1'b1; sAddr = 10'd999; sData = 10'h123;
        exp_push(2, cyc + 1, sAddr, sData);
        @(negedge inClock); sAddr = 10'd1000; sData = 10'h321;
        @(negedge inClock); valid2 = 1'b0;
        check("drop.we", we2, 0);
        check("drop.hold_addr", wa2, 999);
        check("drop.hold_data", wd2, 10'h123);
        check("drop.ready", ready2, 1);
        repeat (3) @(negedge inClock);
        check_writes("drop");

        for (int i = 0; i < 150; i++) begin
            @(negedge inClock);
            valid1 = 1'($urandom_range(0, 1));
            valid2 = 1'($urandom_range(0, 1));
            sAddr  = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(990, 1023)) : 10'($urandom_range(0, 1023));
            sData  = 10'($urandom);
            if (valid1) exp_push(1, cyc + 1, sAddr, sData);
            if (valid2 && sAddr < 10'd1000) exp_push(2, cyc + 1, sAddr, sData);
        end
        @(negedge inClock); valid1 = 1'b0; valid2 = 1'b0;
        repeat (3) @(negedge inClock);
        check_writes("stream_rand");
        check_done("stream_rand", 0, 0, 0, 0);

        // Vblank-synchronised clear, with an ignored second clear mid-sweep.
        @(negedge inClock); clear1 = 1'b1; cValue = 10'h155; c = cyc;
        @(negedge inClock); clear1 = 1'b0;
        check("wait.busy", busy1, 1);
        check("wait.ready", ready1, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge inClock);
            valid1 = 1'($urandom_range(0, 1));
            sAddr  = 10'($urandom);
            sData  = 10'($urandom);
        end
        @(negedge inClock); valid1 = 1'b0;
        check("wait.we", we1, 0);
        check("wait.ready2", ready1, 0);
        vBlank = 1'b1; first = cyc + 2;
        exp_sweep(1, first, 1024, 10'h155, 1'b0);
        repeat (3) @(negedge inClock);
        vBlank = 1'b0;
        wait_to(first + 100);
        clear1 = 1'b1; cValue = 10'h001;
        @(negedge inClock); clear1 = 1'b0;
        wait_to(first + 1023);
        check("sweep.last_we", we1, 1);
        check("sweep.last_addr", wa1, 1023);
        check("sweep.last_busy", busy1, 1);
        @(negedge inClock);
        check("sweep.done", sd1, 1);
        check("sweep.done_busy", busy1, 0);
        check("sweep.done_we", we1, 0);
        check("sweep.done_ready", ready1, 1);
        repeat (30) @(negedge inClock);
        check("sweep.idle_busy", busy1, 0);
        check_writes("sweep_sync");
        check_done("sweep_sync", 1, first + 1024, 0, 0);

        // Clear and sample on the same edge, on both builds.
        @(negedge inClock); vBlank = 1'b1;
        @(negedge inClock);
        valid1 = 1'b1; valid2 = 1'b1; clear1 = 1'b1; clear2 = 1'b1;
        sAddr = 10'd3; sData = 10'h0AA; cValue = 10'($urandom); c = cyc;
        exp_push(1, c + 1, 10'd3, 10'h0AA);
        exp_sweep(1, c + 3, 1024, cValue, 1'b0);
        exp_push(2, c + 1, 10'd3, 10'h0AA);
        exp_sweep(2, c + 2, 1000, cValue, 1'b0);
        @(negedge inClock); valid1 = 1'b0; valid2 = 1'b0; clear1 = 1'b0; clear2 = 1'b0;
        wait_to(c + 3 + 1024 + 5);
        check_writes("same_edge");
        check_done("same_edge", 1, c + 3 + 1024, 1, c + 2 + 1000);

        // Reset in the middle of a sweep, then a fresh full sweep.
        @(negedge inClock); clear1 = 1'b1; cValue = 10'h0F0; c = cyc;
        @(negedge inClock); clear1 = 1'b0;
        first = c + 3;
        for (int a = 0; a <= 500; a++) exp_push(1, first + a, 10'(a), 10'h0F0);
        wait_to(first + 500);
        check("midrst.addr", wa1, 500);
        reset = 1'b1;
        @(negedge inClock);
        check("midrst.we", we1, 0);
        check("midrst.busy", busy1, 0);
        check("midrst.ready", ready1, 1);
        reset = 1'b0;
        repeat (5) @(negedge inClock);
        check_writes("midrst");
        check_done("midrst", 0, 0, 0, 0);
        @(negedge inClock); clear1 = 1'b1; cValue = 10'h3C3; c = cyc;
        @(negedge inClock); clear1 = 1'b0;
        exp_sweep(1, c + 3, 1024, 10'h3C3, 1'b0);
        wait_to(c + 3 + 1024 + 5);
        check_writes("after_rst");
        check_done("after_rst", 1, c + 3 + 1024, 0, 0);

`ifdef VRAM_RAMP_PATTERN_EN
        @(negedge inClock); ramp1 = 1'b1; c = cyc;
        @(negedge inClock); ramp1 = 1'b0;
        exp_sweep(1, c + 3, 1024, 10'h000, 1'b1);
        wait_to(c + 3 + 1024 + 5);
        check_writes("ramp");
        check_done("ramp", 1, c + 3 + 1024, 0, 0);
        @(negedge inClock); ramp1 = 1'b1; clear1 = 1'b1; cValue = 10'h0C5; c = cyc;
        @(negedge inClock); ramp1 = 1'b0; clear1 = 1'b0;
        exp_sweep(1, c + 3, 1024, 10'h0C5, 1'b0);
        wait_to(c + 3 + 1024 + 5);
        check_writes("ramp_vs_clear");
        check_done("ramp_vs_clear", 1, c + 3 + 1024, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
